booth_mult_seq: RTL and testbench
=================================

// Module: booth_mult_seq
// PURPOSE
//  Parametrised sequential radix-2 Booth multiplier: control FSM, counter and A/Q/Q-1/M datapath in one block.
//  Multiplies two WIDTH-bit operands, signed or unsigned, selected per operation.
//  Ready/valid handshake on both the operand and the result side.
//  Serves as the multiply unit behind the bus front-end.
// PARAMETERS
//  WIDTH    4   operand width in bits; legal range >= 2; product width is 2*WIDTH
//  CNT_W    $clog2(WIDTH+2)   iteration counter width; derived, not overridden
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst_n        in   1        synchronous active-low reset, sampled on rising edge of clk
//  start_valid  in   1        operands presented
//  start_ready  out  1        block can accept operands (high only in IDLE)
//  signed_mode  in   1        1 = two's-complement operands, 0 = unsigned; sampled at accept
//  mcand        in   WIDTH    multiplicand M
//  mplier       in   WIDTH    multiplier Q
//  res_valid    out  1        product valid, held until consumed
//  res_ready    in   1        consumer accepts product
//  product      out  2*WIDTH  result, stable while res_valid
//  busy         out  1        high in RUN and DONE
// BEHAVIOUR
//  Reset: state IDLE; start_ready=1, res_valid=0, busy=0, product=0; internal A/Q/Q-1/M/cnt = 0.
//  Reset has priority over every other event, including mid-RUN and DONE; the in-flight operation is lost.
//  Extension: at accept, M and Q are extended to WIDTH+1 bits (sign-extend if signed_mode, else zero-extend).
//   A is WIDTH+1 bits; no overflow is possible because extended operands never equal -2^WIDTH.
//  States IDLE, RUN, DONE.
//  IDLE: start_valid & start_ready at edge E0 -> load M, Q, A=0, Q-1=0, cnt=WIDTH+1; go to RUN.
//  RUN: one Booth iteration per cycle. Decode {Q[0],Q-1}:
//   10 -> A=A-M; 01 -> A=A+M; 00/11 -> no add.
//   Then arithmetic right shift of {A,Q,Q-1} by 1, and cnt-1.
//  RUN -> DONE on the edge where cnt goes 1 -> 0: edge E0+WIDTH+1.
//   product = lower 2*WIDTH bits of {A,Q} is registered on that same edge; res_valid=1 from then on.
//  DONE: product and res_valid held while res_ready=0.
//   res_valid & res_ready -> IDLE next edge; res_valid drops and product keeps its last value.
//  start_valid outside IDLE is ignored (start_ready=0); there is no queuing.
//   A start in the same cycle as a DONE handshake is accepted only in the following IDLE cycle.
//  Operand inputs are don't-care except at the accept edge.
//  Fixed latency without the option: WIDTH+1 cycles from accept to res_valid; throughput one op per WIDTH+3 cycles minimum.
//  Edge cases:
//   WIDTH=4 signed -8*-8 = +64 (8'h40).
//   Signed -8*7 = -56 (8'hC8).
//   Unsigned 15*15 = 225 (8'hE1).
// CONFIGURATION
//  Macro BOOTH_EARLY_TERM_EN.
//  Defined: in RUN, if the unprocessed Q bits and Q-1 are all 0 or all 1, remaining iterations are add-free.
//   The block then applies one arithmetic right shift of {A,Q} by cnt, forms product, and goes to DONE on that edge.
//   Latency is 1..WIDTH+1 cycles; the product is identical to non-terminated operation.
//  Undefined: no early exit; latency is always exactly WIDTH+1.
// STRUCTURE
//  Package booth_pkg holds:
//   state encoding constants ST_IDLE/ST_RUN/ST_DONE (2 bits);
//   op constants OP_ADD=0, OP_SUB=1;
//   Booth decode function booth_op({q0,qneg}) -> {en,op}.
//  Sub-module booth_addsub: combinational (WIDTH+1)-bit adder/subtractor, ports a, b, sub, sum.
//  The FSM, counter, shift registers and early-term detect stay in booth_mult_seq.
// TESTING
//  T1 W=4 unsigned 3*5 -> product=8'h0F; res_valid exactly 5 cycles after accept (no EARLY_TERM).
//  T2 W=4 signed exhaustive 16x16 -> all products match the reference model.
//   Repeat unsigned; includes -8*-8=8'h40, -3*7=8'hEB, 15*15=8'hE1.
//  T3 hold res_ready=0 for 10 cycles -> product and res_valid stable; start_valid pulses ignored, start_ready=0.
//  T4 rst_n=0 at the 3rd RUN cycle -> next edge IDLE, res_valid=0, product=0; new op 2*2=4 then correct.
//  T5 back-to-back: res_ready tied 1, start_valid tied 1 -> one op every WIDTH+3 cycles, no lost or duplicated results.
//  T6 BOOTH_EARLY_TERM_EN, W=8 unsigned 5*1 -> product=16'h0005 with latency <3 cycles.
//   Random ops match non-EN products.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared types and helpers for the sequential radix-2 Booth multiplier.
//   - state_t    : FSM encoding (ST_IDLE / ST_RUN / ST_DONE, 2 bits)
//   - OP_ADD/SUB : adder/subtractor select values
//   - boothCtl_t : decoded iteration control {en, op}
//   - booth_op() : radix-2 Booth decode of {Q[0], Q-1}
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef struct packed {
      logic en;   // an add/sub happens this iteration
      logic op;   // OP_ADD or OP_SUB
   } boothCtl_t;

   // 10 -> A-M, 01 -> A+M, 00/11 -> shift only
   function automatic boothCtl_t booth_op(input logic [1:0] pair);
      boothCtl_t c;
      c.en = pair[1] ^ pair[0];
      c.op = pair[1] ? OP_SUB : OP_ADD;
      return c;
   endfunction

endpackage

// File: rtl/booth_addsub.sv
// booth_addsub
//   Combinational (WIDTH+1)-bit adder/subtractor for the Booth accumulator.
//   Ports:
//     a   in  WIDTH+1  accumulator A
//     b   in  WIDTH+1  multiplicand M (already extended)
//     sub in  1        1 = a - b, 0 = a + b
//     sum out WIDTH+1  result, wraps modulo 2^(WIDTH+1)
module booth_addsub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0] a,
   input  logic [WIDTH:0] b,
   input  logic           sub,
   output logic [WIDTH:0] sum
);

   assign sum = sub ? (a - b) : (a + b);

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq
//   Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
//   unsigned per operation. One Booth iteration per clock; ready/valid on both
//   the operand and result sides. Synchronous active-low reset.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     start_valid/ready    operand handshake (ready only in IDLE)
//     signed_mode          1 = two's complement operands, sampled at accept
//     mcand, mplier        multiplicand M, multiplier Q (WIDTH bits)
//     res_valid/ready      result handshake, product held until consumed
//     product              2*WIDTH result, keeps last value after handoff
//     busy                 high in RUN and DONE
//   Build option:
//     BOOTH_EARLY_TERM_EN  finish as soon as the remaining iterations are
//                          add-free (latency 1..WIDTH+1 instead of WIDTH+1).
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_valid,
   output logic               start_ready,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int CNT_W = $clog2(WIDTH + 2);
   localparam int XW    = WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH + 1);

   state_t             state, stateNext;
   logic [XW-1:0]      regA, regQ, regM;
   logic               qNeg;
   logic [CNT_W-1:0]   cnt, cntNext;
   logic [2*WIDTH-1:0] prodReg;

   boothCtl_t          ctl;
   logic [XW-1:0]      sum, aSel, aNext, qNext;
   logic               qNegNext;
   logic               accept, finish, earlyTerm;
   logic [2*WIDTH-1:0] prodNext;

   // ---------------- one Booth iteration (combinational) ----------------
   assign ctl = booth_op({regQ[0], qNeg});

   booth_addsub #(.WIDTH(WIDTH)) uAddSub (
      .a   (regA),
      .b   (regM),
      .sub (ctl.op),
      .sum (sum)
   );

   assign aSel     = ctl.en ? sum : regA;
   // arithmetic right shift of {A,Q,Q-1}
   assign aNext    = {aSel[XW-1], aSel[XW-1:1]};
   assign qNext    = {aSel[0], regQ[XW-1:1]};
   assign qNegNext = regQ[0];
   assign cntNext  = cnt - CNT_W'(1);

`ifdef BOOTH_EARLY_TERM_EN
   // After this iteration, the low cntNext bits of Q plus Q-1 feed the
   // remaining decodes. If they are uniform no further add happens, so the
   // rest of the work collapses into one shift of {A,Q} by cntNext.
   logic [XW-1:0]          remMask;
   logic signed [2*XW-1:0] aqShift;

   assign remMask   = (XW'(1) << cntNext) - XW'(1);
   assign earlyTerm = (((qNext & remMask) == '0)      && !qNegNext) ||
                      (((qNext & remMask) == remMask) &&  qNegNext);
   assign aqShift   = $signed({aNext, qNext}) >>> cntNext;
   assign prodNext  = (2*WIDTH)'(aqShift);
`else
   assign earlyTerm = 1'b0;
   assign prodNext  = (2*WIDTH)'({aNext, qNext});
`endif

   assign finish = (cntNext == '0) || earlyTerm;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b0;
      accept      = 1'b0;
      case (state)
         ST_IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               accept    = 1'b1;
               stateNext = ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (finish) stateNext = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) stateNext = ST_IDLE;
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   // Operands are extended by one bit so the signed and unsigned cases share
   // the same signed Booth datapath; -2^WIDTH is unreachable, so A never
   // overflows.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regA    <= '0;
         regQ    <= '0;
         regM    <= '0;
         qNeg    <= 1'b0;
         cnt     <= '0;
         prodReg <= '0;
      end else if (accept) begin
         regM <= {signed_mode & mcand[WIDTH-1], mcand};
         regQ <= {signed_mode & mplier[WIDTH-1], mplier};
         regA <= '0;
         qNeg <= 1'b0;
         cnt  <= CNT_INIT;
      end else if (state == ST_RUN) begin
         regA <= aNext;
         regQ <= qNext;
         qNeg <= qNegNext;
         cnt  <= finish ? '0 : cntNext;
         if (finish) prodReg <= prodNext;
      end
   end

   assign product = prodReg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq
//   Self-checking bench for booth_mult_seq: a WIDTH=4 instance for the main
//   scenarios and a WIDTH=8 instance for the early-termination scenario.
//   Expected products come from an integer reference model and travel through
//   a scoreboard queue from stimulus to result.
module tb_booth_mult_seq;

   logic       clk;
   logic       rstN;

   // WIDTH=4 instance
   logic       startValid, startReady, signedMode, resValid, resReady, busy;
   logic [3:0] mcand, mplier;
   logic [7:0] product;

   // WIDTH=8 instance
   logic        eStartValid, eStartReady, eSignedMode, eResValid, eResReady, eBusy;
   logic [7:0]  eMcand, eMplier;
   logic [15:0] eProduct;

   int nChecks = 0;
   int nFail   = 0;

   logic [7:0]  expQ [$];
   logic [15:0] expQ8 [$];

   booth_mult_seq #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rstN),
      .start_valid(startValid), .start_ready(startReady), .signed_mode(signedMode),
      .mcand(mcand), .mplier(mplier),
      .res_valid(resValid), .res_ready(resReady), .product(product), .busy(busy)
   );

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rstN),
      .start_valid(eStartValid), .start_ready(eStartReady), .signed_mode(eSignedMode),
      .mcand(eMcand), .mplier(eMplier),
      .res_valid(eResValid), .res_ready(eResReady), .product(eProduct), .busy(eBusy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] model4(input logic sm, input logic [3:0] a, input logic [3:0] b);
      int x, y;
      x = sm ? int'($signed(a)) : int'(a);
      y = sm ? int'($signed(b)) : int'(b);
      return 8'(x * y);
   endfunction

   function automatic logic [15:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
      int x, y;
      x = sm ? int'($signed(a)) : int'(a);
      y = sm ? int'($signed(b)) : int'(b);
      return 16'(x * y);
   endfunction

   // Drive one W=4 operation and return product/latency; no checking here.
   task automatic runOp(input logic sm, input logic [3:0] a, input logic [3:0] b,
                        output logic [7:0] p, output int lat, output bit tmo);
      int n = 0;
      @(negedge clk);
      while (!startReady && n < 50) begin @(negedge clk); n++; end
      signedMode = sm; mcand = a; mplier = b; startValid = 1'b1; resReady = 1'b1;
      @(negedge clk);
      startValid = 1'b0;
      mcand = 4'($urandom); mplier = 4'($urandom); signedMode = 1'($urandom);
      lat = 0;
      while (!resValid && lat < 50) begin @(negedge clk); lat++; end
      tmo = !resValid || (n >= 50);
      p = product;
   endtask

   task automatic runOp8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] p, output int lat, output bit tmo);
      int n = 0;
      @(negedge clk);
      while (!eStartReady && n < 50) begin @(negedge clk); n++; end
      eSignedMode = sm; eMcand = a; eMplier = b; eStartValid = 1'b1; eResReady = 1'b1;
      @(negedge clk);
      eStartValid = 1'b0;
      eMcand = 8'($urandom); eMplier = 8'($urandom); eSignedMode = 1'($urandom);
      lat = 0;
      while (!eResValid && lat < 50) begin @(negedge clk); lat++; end
      tmo = !eResValid || (n >= 50);
      p = eProduct;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      startValid = 0; signedMode = 0; mcand = 0; mplier = 0; resReady = 0;
      eStartValid = 0; eSignedMode = 0; eMcand = 0; eMplier = 0; eResReady = 0;
      repeat (3) @(negedge clk);
      nChecks++;
      if (startReady !== 1'b1 || resValid !== 1'b0 || busy !== 1'b0 || product !== 8'h00) begin
         nFail++;
         $display("FAIL reset: ready=%b valid=%b busy=%b product=%h, want 1 0 0 00",
                  startReady, resValid, busy, product);
      end
      nChecks++;
      if (eStartReady !== 1'b1 || eResValid !== 1'b0 || eProduct !== 16'h0000) begin
         nFail++;
         $display("FAIL reset8: ready=%b valid=%b product=%h, want 1 0 0000",
                  eStartReady, eResValid, eProduct);
      end
      rstN = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] p, e; int lat; bit tmo;
      expQ.push_back(model4(1'b0, 4'd3, 4'd5));
      runOp(1'b0, 4'd3, 4'd5, p, lat, tmo);
      e = expQ.pop_front();
      nChecks++;
      if (tmo || p !== e) begin
         nFail++; $display("FAIL basic 3*5: got %h tmo=%0d, want %h", p, tmo, e);
      end
      nChecks++;
`ifdef BOOTH_EARLY_TERM_EN
      if (lat < 1 || lat > 5) begin
         nFail++; $display("FAIL basic latency: got %0d, want 1..5", lat);
      end
`else
      if (lat != 5) begin
         nFail++; $display("FAIL basic latency: got %0d, want 5", lat);
      end
`endif
   endtask

   task automatic test_exhaustive();
      logic [7:0] p, e; int lat; bit tmo;
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               expQ.push_back(model4(s[0], 4'(a), 4'(b)));
               runOp(s[0], 4'(a), 4'(b), p, lat, tmo);
               e = expQ.pop_front();
               nChecks++;
               if (tmo || p !== e) begin
                  nFail++;
                  $display("FAIL exhaustive signed=%0d %0d*%0d: got %h tmo=%0d, want %h",
                           s, a, b, p, tmo, e);
               end
            end
   endtask

   task automatic test_hold();
      logic [7:0] e; int n = 0;
      @(negedge clk);
      signedMode = 0; mcand = 4'd3; mplier = 4'd5; resReady = 1'b0; startValid = 1'b1;
      expQ.push_back(model4(1'b0, 4'd3, 4'd5));
      @(negedge clk);
      startValid = 1'b0;
      while (!resValid && n < 50) begin @(negedge clk); n++; end
      e = expQ.pop_front();
      nChecks++;
      if (!resValid || product !== e) begin
         nFail++; $display("FAIL hold first result: valid=%b got %h, want 1 %h", resValid, product, e);
      end
      for (int i = 0; i < 10; i++) begin
         startValid = i[0]; mcand = 4'($urandom); mplier = 4'($urandom);
         @(negedge clk);
         nChecks++;
         if (resValid !== 1'b1 || product !== e || startReady !== 1'b0 || busy !== 1'b1) begin
            nFail++;
            $display("FAIL hold cycle %0d: valid=%b product=%h ready=%b busy=%b, want 1 %h 0 1",
                     i, resValid, product, startReady, busy, e);
         end
      end
      // start offered during the handshake cycle: taken only in the next IDLE cycle
      startValid = 1'b1; signedMode = 0; mcand = 4'd2; mplier = 4'd6; resReady = 1'b1;
      expQ.push_back(model4(1'b0, 4'd2, 4'd6));
      @(negedge clk);
      nChecks++;
      if (resValid !== 1'b0 || startReady !== 1'b1 || product !== e) begin
         nFail++;
         $display("FAIL hold release: valid=%b ready=%b product=%h, want 0 1 %h",
                  resValid, startReady, product, e);
      end
      @(negedge clk);
      startValid = 1'b0;
      nChecks++;
      if (busy !== 1'b1 || startReady !== 1'b0) begin
         nFail++; $display("FAIL hold restart: busy=%b ready=%b, want 1 0", busy, startReady);
      end
      n = 0;
      while (!resValid && n < 50) begin @(negedge clk); n++; end
      e = expQ.pop_front();
      nChecks++;
      if (!resValid || product !== e) begin
         nFail++; $display("FAIL hold second result: valid=%b got %h, want 1 %h", resValid, product, e);
      end
   endtask

   task automatic test_reset_midrun();
      logic [7:0] p, e; int lat; bit tmo;
      @(negedge clk);
      signedMode = 0; mcand = 4'd7; mplier = 4'd7; resReady = 1'b1; startValid = 1'b1;
      @(negedge clk);           // RUN cycle 1
      startValid = 1'b0;
      @(negedge clk);           // RUN cycle 2
      @(negedge clk);           // RUN cycle 3
      rstN = 1'b0;
      @(negedge clk);
      nChecks++;
      if (startReady !== 1'b1 || resValid !== 1'b0 || busy !== 1'b0 || product !== 8'h00) begin
         nFail++;
         $display("FAIL midrun reset: ready=%b valid=%b busy=%b product=%h, want 1 0 0 00",
                  startReady, resValid, busy, product);
      end
      rstN = 1'b1;
      expQ.push_back(model4(1'b0, 4'd2, 4'd2));
      runOp(1'b0, 4'd2, 4'd2, p, lat, tmo);
      e = expQ.pop_front();
      nChecks++;
      if (tmo || p !== e) begin
         nFail++; $display("FAIL after reset 2*2: got %h tmo=%0d, want %h", p, tmo, e);
      end
   endtask

   task automatic test_back_to_back();
      int nAcc = 0, nRes = 0, cyc = 0, lastAcc = -1;
      logic [3:0] a, b; logic sm; logic [7:0] e;
      resReady = 1'b1;
      while (nRes < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (resValid) begin
            nChecks++;
            if (expQ.size() == 0) begin
               nFail++; $display("FAIL b2b duplicate result: got %h, want none", product);
            end else begin
               e = expQ.pop_front();
               if (product !== e) begin
                  nFail++; $display("FAIL b2b result %0d: got %h, want %h", nRes, product, e);
               end
            end
            nRes++;
         end
         if (startReady && nAcc < 8) begin
            a = 4'($urandom); b = 4'($urandom); sm = 1'($urandom);
            signedMode = sm; mcand = a; mplier = b; startValid = 1'b1;
            expQ.push_back(model4(sm, a, b));
`ifndef BOOTH_EARLY_TERM_EN
            if (lastAcc >= 0) begin
               nChecks++;
               if (cyc - lastAcc != 7) begin
                  nFail++; $display("FAIL b2b spacing: got %0d cycles, want 7", cyc - lastAcc);
               end
            end
`endif
            lastAcc = cyc;
            nAcc++;
         end else if (nAcc >= 8) begin
            startValid = 1'b0;
         end
      end
      startValid = 1'b0;
      nChecks++;
      if (nRes != 8 || expQ.size() != 0) begin
         nFail++; $display("FAIL b2b count: got %0d results, %0d pending, want 8 and 0", nRes, expQ.size());
      end
   endtask

   task automatic test_early_term();
      logic [15:0] p, e; int lat; bit tmo;
      logic [7:0] a, b; logic sm;
      expQ8.push_back(model8(1'b0, 8'd5, 8'd1));
      runOp8(1'b0, 8'd5, 8'd1, p, lat, tmo);
      e = expQ8.pop_front();
      nChecks++;
      if (tmo || p !== e) begin
         nFail++; $display("FAIL early 5*1: got %h tmo=%0d, want %h", p, tmo, e);
      end
      nChecks++;
`ifdef BOOTH_EARLY_TERM_EN
      if (lat >= 3 || lat < 1) begin
         nFail++; $display("FAIL early latency: got %0d, want 1..2", lat);
      end
`else
      if (lat != 9) begin
         nFail++; $display("FAIL early latency: got %0d, want 9", lat);
      end
`endif
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom); b = (i < 4) ? 8'(i) : 8'($urandom); sm = 1'($urandom);
         expQ8.push_back(model8(sm, a, b));
         runOp8(sm, a, b, p, lat, tmo);
         e = expQ8.pop_front();
         nChecks++;
         if (tmo || p !== e || lat < 1 || lat > 9) begin
            nFail++;
            $display("FAIL early random signed=%0d %h*%h: got %h lat=%0d, want %h lat 1..9",
                     sm, a, b, p, lat, e);
         end
      end
   endtask

   initial begin
      rstN = 1'b0;
      test_reset();
      test_basic();
      test_exhaustive();
      test_hold();
      test_reset_midrun();
      test_back_to_back();
      test_early_term();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
